spi_frame_ctrl: RTL and testbench

SPI-slave frame sequencer that drives the 6-bit header shift decoder and then runs the payload phase of each frame. It synchronises raw SCLK/CSn/MOSI into the system clock, gates the decoder's shift enable, and decodes the captured header into a register access. For writes it collects a DW-bit payload and issues a write strobe; for reads it fetches register data and shifts it out on MISO. It sits between the SPI pins and the radar-control register file.

---
 rtl/spi_frame_ctrl_pkg.sv | 20 ++
 rtl/spi_pin_sync.sv | 36 +++
 rtl/spi_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_ctrl_pkg.sv
// Shared header layout and frame-sequencer state encoding for the SPI slave
// frame controller.
package spi_frame_ctrl_pkg;

  localparam int unsigned HDR_W    = 6;
  localparam int unsigned RW_BIT   = 5;
  localparam int unsigned ADDR_MSB = 4;
  localparam int unsigned ADDR_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CAPT,
    RDREQ,
    RDLD,
    PAY,
    DONE
  } frameStateT;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser plus registered rise/fall detect for one asynchronous SPI pin.
// All outputs share the same latency (SYNC+1), so pins stay mutually aligned.
module spi_pin_sync #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] stages;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stages <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else if (clr) begin
      stages <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      stages <= {stages[SYNC-2:0], pin};
      level  <= stages[SYNC-1];
      rise   <= stages[SYNC-1] & ~level;
      fall   <= ~stages[SYNC-1] & level;
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI-slave frame sequencer: gates the external header decoder, decodes the
// header into a register access and runs the write/read payload phase.
module spi_frame_ctrl
  import spi_frame_ctrl_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned SYNC = 2
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iCLR,
  input  logic              iSCLK,
  input  logic              iCSn,
  input  logic              iMOSI,
  input  logic [HDR_W-1:0]  iHEADER,
  input  logic              iHEADER_EN,
  input  logic [DW-1:0]     iRDATA,
  output logic              oSHIFT_EN,
  output logic              oDEC_CLR,
  output logic              oMOSI,
  output logic              oMISO,
  output logic [ADDR_W-1:0] oADDR,
  output logic [DW-1:0]     oWDATA,
  output logic              oWE,
  output logic              oRE,
  output logic              oBUSY,
  output logic              oERR
);

  localparam int unsigned CW = $clog2(DW + 1);

  frameStateT state, nextState;

  logic sclkLevel, sclkRise, sclkFall;
  logic csnLevel, csEnd, csStart;
  logic mosiLevel, mosiRise, mosiFall;

  logic [CW-1:0] cnt;
  logic [DW-1:0] misoSr;
  logic          isWrite;
  logic          lastRise;

  spi_pin_sync #(.SYNC(SYNC)) sclkSync (
    .clk(iCLK), .rstN(iRSTn), .clr(iCLR), .pin(iSCLK),
    .level(sclkLevel), .rise(sclkRise), .fall(sclkFall)
  );

  spi_pin_sync #(.SYNC(SYNC)) csnSync (
    .clk(iCLK), .rstN(iRSTn), .clr(iCLR), .pin(iCSn),
    .level(csnLevel), .rise(csEnd), .fall(csStart)
  );

  spi_pin_sync #(.SYNC(SYNC)) mosiSync (
    .clk(iCLK), .rstN(iRSTn), .clr(iCLR), .pin(iMOSI),
    .level(mosiLevel), .rise(mosiRise), .fall(mosiFall)
  );

  assign oMOSI    = mosiLevel;
  assign oMISO    = misoSr[DW-1];
  assign oBUSY    = (state != IDLE);
  assign lastRise = sclkRise && (cnt == CW'(DW - 1));

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state <= IDLE;
    end else if (iCLR) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    oDEC_CLR  = 1'b0;
    oERR      = 1'b0;
    oSHIFT_EN = 1'b0;
    oRE       = 1'b0;
    unique case (state)
      IDLE:  if (csStart) begin
               oDEC_CLR  = 1'b1;
               nextState = HDR;
             end
      HDR:   if (!csEnd) begin
               oSHIFT_EN = sclkRise & ~csnLevel;
               if (iHEADER_EN) nextState = CAPT;
             end
      CAPT:  if (!csEnd) nextState = iHEADER[RW_BIT] ? PAY : RDREQ;
      RDREQ: begin
               oRE = 1'b1;
               if (!csEnd) nextState = RDLD;
             end
      RDLD:  if (!csEnd) nextState = PAY;
      PAY:   if (!csEnd && lastRise) nextState = DONE;
      DONE:  if (csEnd) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    // CSn release mid-frame wins over any simultaneous SCLK edge
    if (csEnd && state != IDLE && state != DONE) begin
      nextState = IDLE;
      oDEC_CLR  = 1'b1;
      oERR      = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oADDR   <= '0;
      oWDATA  <= '0;
      oWE     <= 1'b0;
      isWrite <= 1'b0;
      cnt     <= '0;
      misoSr  <= '0;
    end else if (iCLR) begin
      oADDR   <= '0;
      oWDATA  <= '0;
      oWE     <= 1'b0;
      isWrite <= 1'b0;
      cnt     <= '0;
      misoSr  <= '0;
    end else begin
      oWE <= 1'b0;
      unique case (state)
        CAPT: if (!csEnd) begin
                oADDR   <= iHEADER[ADDR_MSB:0];
                isWrite <= iHEADER[RW_BIT];
                cnt     <= '0;
                misoSr  <= '0;
              end
        RDLD: if (!csEnd) misoSr <= iRDATA;
        PAY:  if (!csEnd) begin
                if (sclkRise) begin
                  cnt <= cnt + 1'b1;
                  if (isWrite) begin
                    oWDATA <= {oWDATA[DW-2:0], mosiLevel};
                    oWE    <= lastRise;
                  end
                end else if (sclkFall && !isWrite && cnt != '0) begin
                  misoSr <= {misoSr[DW-2:0], 1'b0};
                end
              end
        default: ;
      endcase
      // MISO returns low once a frame is over, whether completed or aborted
      if (state != IDLE && nextState == IDLE) misoSr <= '0;
    end
  end

  mosiSetupA: assert property (@(posedge iCLK) disable iff (!iRSTn)
    !(sclkRise && (mosiRise || mosiFall)));

  mode0IdleA: assert property (@(posedge iCLK) disable iff (!iRSTn)
    csStart |-> !sclkLevel);

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Scoreboard bench for spi_frame_ctrl with a behavioural header decoder and
// register-file read port.
module tb_spi_frame_ctrl;

  localparam int unsigned DW   = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 12;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          clr = 1'b0;
  logic          sclk = 1'b0;
  logic          csn = 1'b1;
  logic          mosi = 1'b0;
  logic [5:0]    header;
  logic          headerEn;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] rdValue = '0;

  logic          shiftEn, decClr, mosiOut, miso, we, re, busy, err;
  logic [4:0]    addr;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  spi_frame_ctrl #(.DW(DW), .SYNC(SYNC)) dut (
    .iCLK(clk), .iRSTn(rstN), .iCLR(clr),
    .iSCLK(sclk), .iCSn(csn), .iMOSI(mosi),
    .iHEADER(header), .iHEADER_EN(headerEn), .iRDATA(rdata),
    .oSHIFT_EN(shiftEn), .oDEC_CLR(decClr), .oMOSI(mosiOut), .oMISO(miso),
    .oADDR(addr), .oWDATA(wdata), .oWE(we), .oRE(re),
    .oBUSY(busy), .oERR(err)
  );

  // Header shift decoder: EN pulses with the 6th shift, header valid next cycle
  logic [5:0]  decSr;
  int unsigned decCnt;
  assign headerEn = shiftEn && (decCnt == 5);

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      decSr  <= '0;
      decCnt <= 0;
      header <= '0;
    end else if (decClr) begin
      decSr  <= '0;
      decCnt <= 0;
    end else if (shiftEn) begin
      decSr  <= {decSr[4:0], mosiOut};
      decCnt <= decCnt + 1;
      if (decCnt == 5) header <= {decSr[4:0], mosiOut};
    end
  end

  always @(posedge clk) if (re) rdata <= rdValue;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned decClrCount = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  logic [4+DW:0] weQ[$];
  logic [4:0]    reQ[$];
  logic          errQ[$];
  logic          misoQ[$];
  logic          misoArm = 1'b0;

  always @(negedge clk) begin
    if (rstN) begin
      if (we) begin
        if (weQ.size() == 0) check("weUnexpected", {31'd0, we}, 32'd0);
        else begin
          logic [4+DW:0] e;
          e = weQ.pop_front();
          check("weAddr", {27'd0, addr}, {27'd0, e[4+DW:DW]});
          check("weData", {24'd0, wdata}, {24'd0, e[DW-1:0]});
        end
      end
      if (re) begin
        if (reQ.size() == 0) check("reUnexpected", {31'd0, re}, 32'd0);
        else check("reAddr", {27'd0, addr}, {27'd0, reQ.pop_front()});
      end
      if (err) begin
        if (errQ.size() == 0) check("errUnexpected", {31'd0, err}, 32'd0);
        else check("errPulse", {31'd0, err}, {31'd0, errQ.pop_front()});
      end
      if (decClr) decClrCount++;
    end
  end

  always @(posedge sclk) begin
    if (misoArm) begin
      if (misoQ.size() == 0) check("misoExtra", {31'd0, miso}, 32'd0);
      else check("misoBit", {31'd0, miso}, {31'd0, misoQ.pop_front()});
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    mosi = b;
    tick(HALF);
    sclk = 1'b1;
    tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [5:0] hdr, input logic [DW-1:0] pay,
                       input int unsigned nPay, input int unsigned extra,
                       input int unsigned gap, input logic isRead,
                       output logic busyEnd);
    csn = 1'b0;
    for (int i = 5; i >= 0; i--) sendBit(hdr[i]);
    misoArm = isRead;
    for (int i = 0; i < int'(nPay); i++) sendBit(pay[DW-1-i]);
    misoArm = 1'b0;
    for (int i = 0; i < int'(extra); i++) sendBit(1'b0);
    tick(HALF);
    busyEnd = busy;
    csn = 1'b1;
    tick(gap);
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "Busy"},  {31'd0, busy},    32'd0);
    check({tag, "We"},    {31'd0, we},      32'd0);
    check({tag, "Re"},    {31'd0, re},      32'd0);
    check({tag, "Err"},   {31'd0, err},     32'd0);
    check({tag, "DecClr"},{31'd0, decClr},  32'd0);
    check({tag, "Shift"}, {31'd0, shiftEn}, 32'd0);
    check({tag, "Miso"},  {31'd0, miso},    32'd0);
    check({tag, "Mosi"},  {31'd0, mosiOut}, 32'd0);
    check({tag, "Addr"},  {27'd0, addr},    32'd0);
    check({tag, "Wdata"}, {24'd0, wdata},   32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       busyEnd;
    logic [7:0] misoExp;

    tick(3);
    checkIdle("rst");
    rstN = 1'b1;
    tick(20);

    // Write frame: addr 5, data 0xA5
    weQ.push_back({5'd5, 8'hA5});
    frame(6'b100101, 8'hA5, DW, 0, 20, 1'b0, busyEnd);
    check("decClrT1", decClrCount, 32'd1);

    // Read frame: addr 12, register value 0x3C shifted out MSB first
    rdValue = 8'h3C;
    reQ.push_back(5'd12);
    misoExp = 8'b0011_1100;
    for (int i = 7; i >= 0; i--) misoQ.push_back(misoExp[i]);
    frame(6'b001100, 8'h00, DW, 0, 20, 1'b1, busyEnd);
    check("misoIdle", {31'd0, miso}, 32'd0);

    // Abort after 4 payload bits, then a clean frame
    errQ.push_back(1'b1);
    frame(6'b110011, 8'hF0, 4, 0, 20, 1'b0, busyEnd);
    check("busyAbort", {31'd0, busy}, 32'd0);
    check("decClrAbort", decClrCount, 32'd4);
    weQ.push_back({5'd3, 8'h5A});
    frame(6'b100011, 8'h5A, DW, 0, 20, 1'b0, busyEnd);

    // 20 extra SCLK edges after the payload
    weQ.push_back({5'd31, 8'h81});
    frame(6'b111111, 8'h81, DW, 10, 20, 1'b0, busyEnd);
    check("busyExtra", {31'd0, busyEnd}, 32'd1);
    check("busyAfter", {31'd0, busy}, 32'd0);

    // Reset after 3 header bits
    csn = 1'b0;
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    rstN = 1'b0;
    #1;
    checkIdle("midRst");
    tick(3);
    rstN = 1'b1;
    csn = 1'b1;
    tick(20);
    weQ.push_back({5'd10, 8'hC3});
    frame(6'b101010, 8'hC3, DW, 0, 20, 1'b0, busyEnd);

    // Back-to-back writes with minimum CSn-high gap
    weQ.push_back({5'd1, 8'h11});
    weQ.push_back({5'd2, 8'hEE});
    frame(6'b100001, 8'h11, DW, 0, SYNC + 2, 1'b0, busyEnd);
    frame(6'b100010, 8'hEE, DW, 0, 20, 1'b0, busyEnd);
    tick(10);

    check("wePending",   weQ.size(),   32'd0);
    check("rePending",   reQ.size(),   32'd0);
    check("errPending",  errQ.size(),  32'd0);
    check("misoPending", misoQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
